// File: rtl/sram_like_responder_pkg.sv
// cpu_defs: shared size encodings and response-queue entry for sram_like_responder
package cpu_defs;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } size_e;
  typedef struct packed {
    logic             wr;
    logic [31:0]      data;
    logic [CNT_W-1:0] cnt;
  } resp_entry;
endpackage

// File: rtl/sram_like_responder_resp_queue.sv
// resp_queue: circular response FIFO whose entries count down to readiness
module resp_queue
  import cpu_defs::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  resp_entry     push_entry,
  input  logic          pop,
  output resp_entry     head,
  output logic          empty,
  output logic [CW-1:0] count
);
  resp_entry mem_q [DEPTH];
  resp_entry mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < DEPTH; i++)
      mem_d[i].cnt = mem_q[i].cnt != '0 ? mem_q[i].cnt - CNT_W'(1) : '0;
    if (push) mem_d[wr_ptr_q] = push_entry;
    wr_ptr_d = push ? (wr_ptr_q == PW'(DEPTH - 1) ? '0 : wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d = pop ? (rd_ptr_q == PW'(DEPTH - 1) ? '0 : rd_ptr_q + PW'(1)) : rd_ptr_q;
    count_d = count_q + CW'(push) - CW'(pop);
    head = mem_q[rd_ptr_q];
    empty = count_q == '0;
    count = count_q;
  end
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/sram_like_responder.sv
// sram_like_responder: SRAM-like request/response slave with in-order fixed-latency completion
module sram_like_responder
  import cpu_defs::*;
#(
  parameter int DEPTH = 4,
  parameter int LATENCY = 2,
  parameter int RAM_AW = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              addr_ok,
  output logic              data_ok,
  output logic [31:0]       rdata,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic s1_valid_q, s1_valid_d, s1_wr_q, s1_wr_d;
  logic [3:0] be;
  logic empty;
  logic [CW-1:0] count;
  resp_entry head, push_entry;
  logic unused_bits;
  always_comb begin
    addr_ok = req && !rst && (CW'(s1_valid_q) + count < CW'(DEPTH));
    be = size == SZ_BYTE ? 4'b0001 << addr[1:0] :
         size == SZ_HALF ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    ram_en = addr_ok;
    ram_we = addr_ok && wr ? be : 4'b0000;
    ram_addr = addr[RAM_AW+1:2];
    ram_wdata = wdata;
    s1_valid_d = addr_ok;
    s1_wr_d = wr;
    push_entry = '{wr: s1_wr_q, data: s1_wr_q ? 32'h0 : ram_rdata, cnt: CNT_W'(LATENCY - 2)};
    data_ok = !rst && !empty && head.cnt == '0;
    rdata = data_ok ? head.data : 32'h0;
    unused_bits = ^{addr[31:RAM_AW+2], head.wr};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_wr_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_wr_q <= s1_wr_d;
    end
  end
  resp_queue #(.DEPTH(DEPTH)) u_queue (
    .clk(clk),
    .rst(rst),
    .push(s1_valid_q),
    .push_entry(push_entry),
    .pop(data_ok),
    .head(head),
    .empty(empty),
    .count(count)
  );
endmodule

// File: tb/tb_sram_like_responder.sv
// tb_sram_like_responder: model-checked bench for two responder instances (latency 2 and 8)
module tb_sram_like_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, req = 1'b0, wr = 1'b0;
  logic [1:0] size = 2'd0;
  logic [31:0] addr = '0, wdata = '0;
  logic aok [2], dok [2], ren [2];
  logic [31:0] rd [2], rwd [2];
  logic [31:0] rrd [2] = '{default: '0};
  logic [3:0] rwe [2];
  logic [13:0] ra [2];
  logic [31:0] ram [2][256] = '{default: '0};
  logic [31:0] mm [2][256] = '{default: '0};
  int done_c [2][64] = '{default: 0};
  logic [31:0] exp_d [2][64] = '{default: '0};
  int hd [2] = '{0, 0};
  int tl [2] = '{0, 0};
  int cyc = 0, checks = 0, errs = 0;
  sram_like_responder #(.DEPTH(4), .LATENCY(2), .RAM_AW(14)) dut0 (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .addr_ok(aok[0]), .data_ok(dok[0]), .rdata(rd[0]), .ram_en(ren[0]), .ram_we(rwe[0]),
    .ram_addr(ra[0]), .ram_wdata(rwd[0]), .ram_rdata(rrd[0]));
  sram_like_responder #(.DEPTH(4), .LATENCY(8), .RAM_AW(14)) dut1 (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .addr_ok(aok[1]), .data_ok(dok[1]), .rdata(rd[1]), .ram_en(ren[1]), .ram_we(rwe[1]),
    .ram_addr(ra[1]), .ram_wdata(rwd[1]), .ram_rdata(rrd[1]));
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk)
    for (int i = 0; i < 2; i++)
      if (ren[i]) begin
        rrd[i] <= ram[i][ra[i][7:0]];
        for (int b = 0; b < 4; b++)
          if (rwe[i][b]) ram[i][ra[i][7:0]][8*b+:8] <= rwd[i][8*b+:8];
      end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask
  function automatic int lat(input int i);
    return i == 0 ? 2 : 8;
  endfunction
  function automatic logic [3:0] be_of(input logic [1:0] sz, input logic [1:0] off);
    if (sz == 2'd0) return 4'(1 << off);
    if (sz == 2'd1) return off[1] ? 4'hC : 4'h3;
    return 4'hF;
  endfunction
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin : model
      logic ea, ed;
      logic [3:0] ewe;
      logic [31:0] er;
      int dn;
      ea = !rst && req && (tl[i] - hd[i]) < 4;
      ed = !rst && tl[i] > hd[i] && done_c[i][hd[i] % 64] == cyc;
      er = ed ? exp_d[i][hd[i] % 64] : 32'h0;
      ewe = (ea && wr) ? be_of(size, addr[1:0]) : 4'h0;
      chk($sformatf("addr_ok%0d", i), 32'(aok[i]), 32'(ea));
      chk($sformatf("data_ok%0d", i), 32'(dok[i]), 32'(ed));
      chk($sformatf("rdata%0d", i), rd[i], er);
      chk($sformatf("ram_en%0d", i), 32'(ren[i]), 32'(ea));
      chk($sformatf("ram_we%0d", i), 32'(rwe[i]), 32'(ewe));
      chk($sformatf("ram_addr%0d", i), 32'(ra[i]), 32'(addr[15:2]));
      chk($sformatf("ram_wdata%0d", i), rwd[i], wdata);
      if (rst) begin
        hd[i] = 0;
        tl[i] = 0;
      end else begin
        if (ed) hd[i]++;
        if (ea) begin
          dn = cyc + lat(i);
          if (tl[i] > hd[i] && done_c[i][(tl[i] - 1) % 64] + 1 > dn)
            dn = done_c[i][(tl[i] - 1) % 64] + 1;
          exp_d[i][tl[i] % 64] = wr ? 32'h0 : mm[i][addr[9:2]];
          done_c[i][tl[i] % 64] = dn;
          tl[i]++;
          for (int b = 0; b < 4; b++)
            if (ewe[b]) mm[i][addr[9:2]][8*b+:8] = wdata[8*b+:8];
        end
      end
    end
  end
  task automatic go(input logic rs, input logic rq, input logic w, input logic [1:0] sz,
                    input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    rst = rs;
    req = rq;
    wr = w;
    size = sz;
    addr = a;
    wdata = d;
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    repeat (n) go(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
  endtask
  initial begin
    int n_aok, first, stray;
    repeat (3) begin
      go(1'b1, 1'b1, 1'b0, 2'd2, 32'h10, 32'h0);
      chk("rst_addr_ok", 32'(aok[0]), 32'h0);
    end
    go(1'b0, 1'b1, 1'b1, 2'd2, 32'h10, 32'hDEADBEEF);
    chk("w_addr_ok", 32'(aok[0]), 32'h1);
    chk("w_ram_we", 32'(rwe[0]), 32'hF);
    chk("w_ram_addr", 32'(ra[0]), 32'h4);
    idle(1);
    chk("w_early_data_ok", 32'(dok[0]), 32'h0);
    idle(1);
    chk("w_data_ok", 32'(dok[0]), 32'h1);
    chk("w_rdata", rd[0], 32'h0);
    idle(10);
    go(1'b0, 1'b1, 1'b0, 2'd2, 32'h10, 32'h0);
    chk("r_addr_ok", 32'(aok[0]), 32'h1);
    idle(2);
    chk("r_data_ok", 32'(dok[0]), 32'h1);
    chk("r_rdata", rd[0], 32'hDEADBEEF);
    idle(10);
    go(1'b0, 1'b1, 1'b1, 2'd0, 32'h13, 32'hAA000000);
    chk("byte_we", 32'(rwe[0]), 32'h8);
    go(1'b0, 1'b1, 1'b1, 2'd1, 32'h12, 32'h12340000);
    chk("half_we", 32'(rwe[0]), 32'hC);
    go(1'b0, 1'b1, 1'b1, 2'd3, 32'h20, 32'h55667788);
    chk("rsvd_we", 32'(rwe[0]), 32'hF);
    idle(10);
    go(1'b0, 1'b1, 1'b0, 2'd2, 32'h10, 32'h0);
    go(1'b0, 1'b1, 1'b0, 2'd2, 32'h20, 32'h0);
    go(1'b0, 1'b1, 1'b0, 2'd2, 32'h14, 32'h0);
    chk("b2b0_data_ok", 32'(dok[0]), 32'h1);
    chk("b2b0_rdata", rd[0], 32'h1234BEEF);
    idle(1);
    chk("b2b1_data_ok", 32'(dok[0]), 32'h1);
    chk("b2b1_rdata", rd[0], 32'h55667788);
    idle(1);
    chk("b2b2_data_ok", 32'(dok[0]), 32'h1);
    chk("b2b2_rdata", rd[0], 32'h0);
    idle(10);
    n_aok = 0;
    first = -1;
    for (int k = 0; k < 9; k++) begin
      go(1'b0, 1'b1, 1'b0, 2'd2, 32'h40 + 32'(4 * k), 32'h0);
      n_aok += int'(aok[1]);
      if (dok[1] && first < 0) first = k;
    end
    chk("credit_accepts", 32'(n_aok), 32'd4);
    chk("credit_first_done", 32'(first), 32'd8);
    idle(20);
    go(1'b0, 1'b1, 1'b0, 2'd2, 32'h10, 32'h0);
    go(1'b0, 1'b1, 1'b0, 2'd2, 32'h20, 32'h0);
    go(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    chk("rst_data_ok", 32'(dok[0]), 32'h0);
    go(1'b0, 1'b1, 1'b0, 2'd2, 32'h20, 32'h0);
    chk("post_rst_addr_ok0", 32'(aok[0]), 32'h1);
    chk("post_rst_addr_ok1", 32'(aok[1]), 32'h1);
    stray = int'(dok[0]) + int'(dok[1]);
    idle(1);
    stray += int'(dok[0]) + int'(dok[1]);
    idle(1);
    chk("post_rst_data_ok0", 32'(dok[0]), 32'h1);
    chk("post_rst_rdata0", rd[0], 32'h55667788);
    stray += int'(dok[1]);
    repeat (5) begin
      idle(1);
      stray += int'(dok[0]) + int'(dok[1]);
    end
    chk("post_rst_stray", 32'(stray), 32'h0);
    idle(1);
    chk("post_rst_data_ok1", 32'(dok[1]), 32'h1);
    chk("post_rst_rdata1", rd[1], 32'h55667788);
    idle(3);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
